// File: rtl/elevator_ctrl_pkg.sv
// Shared types for the four-floor elevator controller.
// Floor index, call vector and FSM state encoding plus call-mask helpers.
package elev_pkg;

    localparam int NUM_FLOORS = 4;

    typedef logic [1:0]            floor_t;
    typedef logic [NUM_FLOORS-1:0] call_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        DOOR_OPEN,
        MOVING
    } elev_state_t;

    // Mask of floors strictly above f.
    function automatic call_vec_t floors_above(floor_t f);
        call_vec_t m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Mask of floors strictly below f.
    function automatic call_vec_t floors_below(floor_t f);
        call_vec_t m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/elevator_ctrl_if.sv
// Call buttons in, registered car/door/call status out to the display stage.
interface elevator_ctrl_if;
    import elev_pkg::*;

    call_vec_t req;
    floor_t    floor_sel;
    logic      door;
    logic      moving;
    logic      dir_up;
    call_vec_t pending;

    modport master (output req, input floor_sel, door, moving, dir_up, pending);
    modport slave  (input req, output floor_sel, door, moving, dir_up, pending);
endinterface

// File: rtl/elevator_ctrl_cycle_timer.sv
// Loadable down-counter saturating at 0; expire flags the final counted cycle.
// A load in the same cycle overrides the decrement.
module cycle_timer #(
    parameter  int MAX = 1,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/elevator_ctrl.sv
// Four-floor elevator FSM: latches calls, sweeps in one direction before reversing,
// times floor transit and door dwell; all outputs registered, no req->output path.
module elevator_ctrl
    import elev_pkg::*;
#(
    parameter int MOVE_CYCLES = 100_000_000,
    parameter int DOOR_CYCLES = 200_000_000
) (
    input  logic            clk,
    input  logic            reset,
    elevator_ctrl_if.slave  bus
);

    localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    elev_state_t state_q, state_d;
    floor_t      floor_q, floor_d;
    logic        dir_up_q, dir_up_d;
    call_vec_t   pend_q, pend_d;
    logic        door_q, door_d;
    logic        moving_q, moving_d;

    call_vec_t   clr;
    call_vec_t   here;
    call_vec_t   ahead, behind;
    logic        eff_up;
    logic        tmr_load;
    logic [TW-1:0] tmr_val;
    logic        tmr_expire;

    cycle_timer #(.MAX(TMAX)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        clr      = '0;
        tmr_load = 1'b0;
        tmr_val  = TW'(DOOR_CYCLES);

        here = call_vec_t'(1) << floor_q;
        // Direction is pinned at the end floors so a sweep can never wrap.
        if (floor_q == 2'd3) begin
            eff_up = 1'b0;
        end else if (floor_q == 2'd0) begin
            eff_up = 1'b1;
        end else begin
            eff_up = dir_up_q;
        end
        ahead  = pend_q & (eff_up ? floors_above(floor_q) : floors_below(floor_q));
        behind = pend_q & (eff_up ? floors_below(floor_q) : floors_above(floor_q));

        case (state_q)
            IDLE: begin
                dir_up_d = eff_up;
                if ((pend_q & here) != '0) begin
                    state_d  = DOOR_OPEN;
                    clr      = here;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(DOOR_CYCLES);
                end else if (ahead != '0) begin
                    state_d  = MOVING;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(MOVE_CYCLES);
                end else if (behind != '0) begin
                    dir_up_d = ~eff_up;
                    state_d  = MOVING;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(MOVE_CYCLES);
                end
            end
            DOOR_OPEN: begin
                // A press at the open floor holds the door instead of queuing a call.
                clr = here;
                if ((bus.req & here) != '0) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(DOOR_CYCLES);
                end else if (tmr_expire) begin
                    state_d = IDLE;
                end
            end
            MOVING: begin
                if (tmr_expire) begin
                    floor_d = dir_up_q ? floor_q + 2'd1 : floor_q - 2'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pend_d   = (pend_q | bus.req) & ~clr;
        door_d   = (state_d == DOOR_OPEN);
        moving_d = (state_d == MOVING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            dir_up_q <= 1'b1;
            pend_q   <= '0;
            door_q   <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_up_q <= dir_up_d;
            pend_q   <= pend_d;
            door_q   <= door_d;
            moving_q <= moving_d;
        end
    end

    assign bus.floor_sel = floor_q;
    assign bus.door      = door_q;
    assign bus.moving    = moving_q;
    assign bus.dir_up    = dir_up_q;
    assign bus.pending   = pend_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed scenarios plus random call traffic against a behavioural car model.
module tb_elevator_ctrl;
    import elev_pkg::*;

    localparam int MOVE = 4;
    localparam int DOOR = 3;
    localparam int M_IDLE = 0, M_DOOR = 1, M_MOVE = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    elevator_ctrl_if bus();

    elevator_ctrl #(.MOVE_CYCLES(MOVE), .DOOR_CYCLES(DOOR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference car: where it is, what it is doing, cycles left in that activity.
    int       m_floor;
    int       m_mode;
    int       m_left;
    bit       m_up;
    bit [3:0] m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step(bit [3:0] r, bit rst);
        bit       up;
        int       above, below;
        bit [3:0] me;
        if (rst) begin
            m_floor = 0; m_mode = M_IDLE; m_left = 0; m_up = 1'b1; m_pend = 4'b0000;
            return;
        end
        me = 4'b0001 << m_floor;
        above = 0;
        below = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i] && i > m_floor) above++;
            if (m_pend[i] && i < m_floor) below++;
        end
        case (m_mode)
            M_IDLE: begin
                up = (m_floor == 3) ? 1'b0 : (m_floor == 0) ? 1'b1 : m_up;
                m_up = up;
                if (m_pend[m_floor]) begin
                    m_mode = M_DOOR; m_left = DOOR;
                    m_pend = (m_pend | r) & ~me;
                end else begin
                    m_pend = m_pend | r;
                    if ((up && above > 0) || (!up && below > 0)) begin
                        m_mode = M_MOVE; m_left = MOVE;
                    end else if (above + below > 0) begin
                        m_up = !up; m_mode = M_MOVE; m_left = MOVE;
                    end
                end
            end
            M_DOOR: begin
                m_pend = (m_pend | r) & ~me;
                if (r[m_floor]) m_left = DOOR;
                else if (m_left == 1) m_mode = M_IDLE;
                else m_left--;
            end
            default: begin
                m_pend = m_pend | r;
                if (m_left == 1) begin
                    m_floor = m_up ? m_floor + 1 : m_floor - 1;
                    m_mode = M_IDLE;
                end else begin
                    m_left--;
                end
            end
        endcase
    endfunction

    task automatic step(input bit [3:0] r, input bit rst);
        @(negedge clk);
        bus.req = r;
        reset = rst;
        @(posedge clk);
        #1;
        model_step(r, rst);
        chk("floor_sel", 32'(bus.floor_sel), 32'(m_floor));
        chk("door", 32'(bus.door), 32'(m_mode == M_DOOR));
        chk("moving", 32'(bus.moving), 32'(m_mode == M_MOVE));
        chk("dir_up", 32'(bus.dir_up), 32'(m_up));
        chk("pending", 32'(bus.pending), 32'(m_pend));
    endtask

    initial begin
        int       door_cnt, last_floor, nchg, bad;
        int       chg[3];
        int       opened[$];
        bit       done, seen_door, saw_down, pend2_set;
        bit [3:0] r;
        bus.req = 4'b0000;

        // 1: reset state
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("rst_floor", 32'(bus.floor_sel), 0);
        chk("rst_door", 32'(bus.door), 0);
        chk("rst_moving", 32'(bus.moving), 0);
        chk("rst_dir_up", 32'(bus.dir_up), 1);
        chk("rst_pending", 32'(bus.pending), 0);

        // 2: call at current floor
        step(4'b0001, 1'b0);
        chk("t2_pend_latched", 32'(bus.pending), 32'h1);
        door_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 1'b0);
            if (bus.door) door_cnt++;
        end
        chk("t2_door_cycles", door_cnt, DOOR);
        chk("t2_pend_clear", 32'(bus.pending), 0);
        chk("t2_door_closed", 32'(bus.door), 0);

        // 3: travel 0 -> 3
        step(4'b0000, 1'b1);
        step(4'b1000, 1'b0);
        last_floor = 0; nchg = 0; bad = 0; done = 0; seen_door = 0; door_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            step(4'b0000, 1'b0);
            if (int'(bus.floor_sel) != last_floor) begin
                if (nchg < 3) chg[nchg] = i;
                nchg++;
                last_floor = int'(bus.floor_sel);
            end
            if (bus.door && bus.moving) bad++;
            if (bus.door) begin
                seen_door = 1;
                door_cnt = int'(bus.floor_sel);
            end else if (seen_door) begin
                done = 1;
                break;
            end
        end
        chk("t3_completed", 32'(done), 1);
        chk("t3_floor_steps", nchg, 3);
        chk("t3_first_step", chg[0], 5);
        chk("t3_step_1_2", chg[1] - chg[0], 5);
        chk("t3_step_2_3", chg[2] - chg[1], 5);
        chk("t3_door_floor", door_cnt, 3);
        chk("t3_door_while_moving", bad, 0);

        // 4: call for floor 0 while going up past 2
        step(4'b0000, 1'b1);
        step(4'b1000, 1'b0);
        done = 0;
        for (int i = 0; i < 30; i++) begin
            step(4'b0000, 1'b0);
            if (bus.floor_sel == 2'd2) begin done = 1; break; end
        end
        chk("t4_reach_2", 32'(done), 1);
        step(4'b0001, 1'b0);
        opened.delete();
        done = 0; saw_down = 0; seen_door = 0;
        for (int i = 0; i < 80; i++) begin
            step(4'b0000, 1'b0);
            if (bus.moving && !bus.dir_up) saw_down = 1;
            if (bus.door && !seen_door) opened.push_back(int'(bus.floor_sel));
            if (!bus.door && seen_door && bus.floor_sel == 2'd0) begin done = 1; break; end
            seen_door = bus.door;
        end
        chk("t4_completed", 32'(done), 1);
        chk("t4_stops", opened.size(), 2);
        if (opened.size() == 2) begin
            chk("t4_first_stop", opened[0], 3);
            chk("t4_second_stop", opened[1], 0);
        end
        chk("t4_went_down", 32'(saw_down), 1);
        chk("t4_pend_empty", 32'(bus.pending), 0);

        // 5: door reopen press at floor 2
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        done = 0;
        for (int i = 0; i < 30; i++) begin
            step(4'b0000, 1'b0);
            if (bus.door) begin done = 1; break; end
        end
        chk("t5_door_opened", 32'(done), 1);
        chk("t5_door_floor", 32'(bus.floor_sel), 2);
        door_cnt = 1; pend2_set = 0;
        step(4'b0000, 1'b0);
        if (bus.door) door_cnt++;
        step(4'b0100, 1'b0);
        if (bus.door) door_cnt++;
        if (bus.pending[2]) pend2_set = 1;
        done = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 1'b0);
            if (bus.pending[2]) pend2_set = 1;
            if (bus.door) door_cnt++;
            else begin done = 1; break; end
        end
        chk("t5_door_closed", 32'(done), 1);
        chk("t5_door_cycles", door_cnt, 5);
        chk("t5_pend2_unlatched", 32'(pend2_set), 0);

        // 6: reset mid-move 1 -> 2
        step(4'b0000, 1'b1);
        step(4'b1100, 1'b0);
        done = 0;
        for (int i = 0; i < 40; i++) begin
            step(4'b0000, 1'b0);
            if (bus.floor_sel == 2'd1 && bus.moving) begin done = 1; break; end
        end
        chk("t6_moving_1_2", 32'(done), 1);
        chk("t6_pend_before", 32'(bus.pending), 32'hC);
        step(4'b0000, 1'b1);
        chk("t6_floor", 32'(bus.floor_sel), 0);
        chk("t6_pending", 32'(bus.pending), 0);
        chk("t6_door", 32'(bus.door), 0);
        chk("t6_moving", 32'(bus.moving), 0);

        // Random call traffic with rare resets
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            step(r, $urandom_range(0, 499) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
